// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32I ALU issue stage: ALU op codes,
// operand-B mux codes, opcode/funct7 constants and the issue FSM state type.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9,
      OP_BEQ  = 4'd10,
      OP_BNE  = 4'd11,
      OP_BLT  = 4'd12,
      OP_BGE  = 4'd13,
      OP_BLTU = 4'd14,
      OP_BGEU = 4'd15
   } alu_op_t;

   typedef enum logic [1:0] {
      MUX_RS2  = 2'd0,
      MUX_IMMI = 2'd1,
      MUX_IMMS = 2'd2
   } irmux_t;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;
   localparam logic [6:0] OPC_S = 7'b0100011;
   localparam logic [6:0] OPC_B = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode for the ALU issue stage: maps an instruction
// word to ALU op, operand-B select, register write enable and illegal flag.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  alu_op,
   output logic [1:0]  irmux,
   output logic        wb_we,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      alu_op  = OP_ADD;
      irmux   = MUX_RS2;
      wb_we   = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OPC_R: begin
            wb_we = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'b000:  alu_op = OP_ADD;
                  3'b001:  alu_op = OP_SLL;
                  3'b010:  alu_op = OP_SLT;
                  3'b011:  alu_op = OP_SLTU;
                  3'b100:  alu_op = OP_XOR;
                  3'b101:  alu_op = OP_SRL;
                  3'b110:  alu_op = OP_OR;
                  default: alu_op = OP_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               alu_op = OP_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               alu_op = OP_SRA;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_I: begin
            irmux = MUX_IMMI;
            wb_we = 1'b1;
            case (funct3)
               3'b000: alu_op = OP_ADD;
               3'b010: alu_op = OP_SLT;
               3'b011: alu_op = OP_SLTU;
               3'b100: alu_op = OP_XOR;
               3'b110: alu_op = OP_OR;
               3'b111: alu_op = OP_AND;
               // shift-immediates reuse funct7 as a real opcode field
               3'b001: begin
                  if (funct7 == F7_BASE) alu_op = OP_SLL;
                  else                   illegal = 1'b1;
               end
               default: begin
                  if (funct7 == F7_BASE)     alu_op = OP_SRL;
                  else if (funct7 == F7_ALT) alu_op = OP_SRA;
                  else                       illegal = 1'b1;
               end
            endcase
         end
         OPC_S: begin
            irmux   = MUX_IMMS;
            alu_op  = OP_ADD;
            illegal = funct3[2] | (funct3 == 3'b011);
         end
         OPC_B: begin
            case (funct3)
               3'b000:  alu_op = OP_BEQ;
               3'b001:  alu_op = OP_BNE;
               3'b100:  alu_op = OP_BLT;
               3'b101:  alu_op = OP_BGE;
               3'b110:  alu_op = OP_BLTU;
               3'b111:  alu_op = OP_BGEU;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         alu_op = OP_ADD;
         irmux  = MUX_RS2;
         wb_we  = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Single-slot ALU issue stage: accepts one RV32I instruction, drives an external
// ALU for one cycle, and holds the captured result until the consumer takes it.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_rs2,
   output logic [DATA_W-1:0] alu_imms,
   output logic [DATA_W-1:0] alu_immi,
   output logic [1:0]        alu_irmux,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_bt,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              br_taken,
   output logic              err,
   output logic [1:0]        fsm_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // producer keeps valid and payload steady until then, ready never waits on valid.

   state_t state, state_nx;

   logic [3:0]        dec_op;
   logic [1:0]        dec_irmux;
   logic              dec_we;
   logic              dec_illegal;
   logic              accept;

   logic [DATA_W-1:0] rs1_q, rs2_q, wb_data_q;
   logic [11:0]       imm_hi_q;
   logic [4:0]        rd_q;
   logic [3:0]        op_q;
   logic [1:0]        irmux_q;
   logic              we_q, err_q, br_q;
   logic              in_exec, in_resp;

   alu_decode u_decode (
      .instr   (instr),
      .alu_op  (dec_op),
      .irmux   (dec_irmux),
      .wb_we   (dec_we),
      .illegal (dec_illegal)
   );

   assign accept = instr_valid && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = dec_illegal ? ST_RESP : ST_EXEC;
         ST_EXEC: state_nx = ST_RESP;
         ST_RESP: if (wb_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_hi_q  <= '0;
         rd_q      <= '0;
         op_q      <= '0;
         irmux_q   <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         br_q      <= 1'b0;
         wb_data_q <= '0;
      end else begin
         if (accept) begin
            rs1_q    <= rs1_data;
            rs2_q    <= rs2_data;
            imm_hi_q <= instr[31:20];
            rd_q     <= instr[11:7];
            op_q     <= dec_op;
            irmux_q  <= dec_irmux;
            we_q     <= dec_we;
            err_q    <= dec_illegal;
            // illegal words skip EXEC, so the response payload is cleared here
            if (dec_illegal) begin
               wb_data_q <= '0;
               br_q      <= 1'b0;
            end
         end
         if (state == ST_EXEC) begin
            wb_data_q <= alu_result;
            br_q      <= alu_bt;
         end
      end
   end

   assign in_exec = (state == ST_EXEC);
   assign in_resp = (state == ST_RESP);

   assign instr_ready = (state == ST_IDLE) && !rst;

   assign alu_a     = in_exec ? rs1_q : '0;
   assign alu_rs2   = in_exec ? rs2_q : '0;
   assign alu_immi  = in_exec ? {{(DATA_W-12){imm_hi_q[11]}}, imm_hi_q} : '0;
   assign alu_imms  = in_exec ? {{(DATA_W-12){imm_hi_q[11]}}, imm_hi_q[11:5], rd_q} : '0;
   assign alu_irmux = in_exec ? irmux_q : 2'd0;
   assign alu_op    = in_exec ? op_q : 4'd0;

   assign wb_valid  = in_resp;
   assign wb_rd     = in_resp ? rd_q : 5'd0;
   assign wb_data   = in_resp ? wb_data_q : '0;
   assign br_taken  = in_resp && br_q;
   assign err       = in_resp && err_q;
   // x0 is hardwired to zero, so a write to it is never requested
   assign wb_we     = in_resp && we_q && !err_q && (rd_q != 5'd0);

   assign fsm_state = state;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: hand-computed vectors, a behavioural ALU
// standing in for the external datapath, and immediate-assertion checks.
module tb_alu_issue;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instr;
   logic [W-1:0]  rs1_data, rs2_data;
   logic [W-1:0]  alu_a, alu_rs2, alu_imms, alu_immi;
   logic [1:0]    alu_irmux;
   logic [3:0]    alu_op;
   logic [W-1:0]  alu_result;
   logic          alu_bt;
   logic          wb_valid, wb_ready, wb_we;
   logic [4:0]    wb_rd;
   logic [W-1:0]  wb_data;
   logic          br_taken, err;
   logic [1:0]    fsm_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue #(.DATA_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .alu_a       (alu_a),
      .alu_rs2     (alu_rs2),
      .alu_imms    (alu_imms),
      .alu_immi    (alu_immi),
      .alu_irmux   (alu_irmux),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_bt      (alu_bt),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .br_taken    (br_taken),
      .err         (err),
      .fsm_state   (fsm_state)
   );

   // external ALU stand-in
   logic [W-1:0] b_sel;
   always_comb begin
      b_sel      = alu_rs2;
      alu_result = '0;
      alu_bt     = 1'b0;
      if (alu_irmux == 2'd1) b_sel = alu_immi;
      else if (alu_irmux == 2'd2) b_sel = alu_imms;
      case (alu_op)
         4'd0:  alu_result = alu_a + b_sel;
         4'd1:  alu_result = alu_a - b_sel;
         4'd2:  alu_result = alu_a & b_sel;
         4'd3:  alu_result = alu_a | b_sel;
         4'd4:  alu_result = alu_a ^ b_sel;
         4'd5:  alu_result = alu_a << b_sel[4:0];
         4'd6:  alu_result = alu_a >> b_sel[4:0];
         4'd7:  alu_result = $unsigned($signed(alu_a) >>> b_sel[4:0]);
         4'd8:  alu_result = {31'd0, $signed(alu_a) < $signed(b_sel)};
         4'd9:  alu_result = {31'd0, alu_a < b_sel};
         4'd10: alu_bt = (alu_a == b_sel);
         4'd11: alu_bt = (alu_a != b_sel);
         4'd12: alu_bt = ($signed(alu_a) < $signed(b_sel));
         4'd13: alu_bt = ($signed(alu_a) >= $signed(b_sel));
         4'd14: alu_bt = (alu_a < b_sel);
         default: alu_bt = (alu_a >= b_sel);
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // offer a word at a falling edge; on return the next falling edge has passed
   task automatic offer(input logic [31:0] i, input logic [W-1:0] a, input logic [W-1:0] b);
      instr_valid = 1'b1;
      instr       = i;
      rs1_data    = a;
      rs2_data    = b;
      #1 check("ready_at_offer", {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = '0;
      rs1_data = '0; rs2_data = '0; wb_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      // R-type ADD x0,x1,x2 offered on the first edge after release
      rst = 1'b0;
      offer(32'h0020_8033, 32'd687, 32'd1684168);
      check("add_alu_op", {28'd0, alu_op}, 32'd0);
      check("add_irmux", {30'd0, alu_irmux}, 32'd0);
      check("add_alu_a", alu_a, 32'd687);
      check("add_alu_rs2", alu_rs2, 32'd1684168);
      check("add_no_valid_yet", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
      check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("add_wb_data", wb_data, 32'd1684855);
      check("add_wb_rd", {27'd0, wb_rd}, 32'd0);
      check("add_wb_we_x0", {31'd0, wb_we}, 32'd0);
      check("add_alu_idle", {28'd0, alu_op}, 32'd0);
      @(negedge clk);
      check("add_done", {31'd0, wb_valid}, 32'd0);

      // ADDI x5,x1,12
      offer(32'h00C0_8293, 32'd687, 32'd0);
      check("addi_irmux", {30'd0, alu_irmux}, 32'd1);
      check("addi_immi", alu_immi, 32'd12);
      @(negedge clk);
      check("addi_wb_data", wb_data, 32'd699);
      check("addi_wb_rd", {27'd0, wb_rd}, 32'd5);
      check("addi_wb_we", {31'd0, wb_we}, 32'd1);
      @(negedge clk);

      // SW x2,12(x1)
      offer(32'h0020_A623, 32'd687, 32'd55);
      check("sw_irmux", {30'd0, alu_irmux}, 32'd2);
      check("sw_imms", alu_imms, 32'd12);
      check("sw_alu_op", {28'd0, alu_op}, 32'd0);
      @(negedge clk);
      check("sw_wb_data", wb_data, 32'd699);
      check("sw_wb_we", {31'd0, wb_we}, 32'd0);
      @(negedge clk);

      // BEQ x1,x2 taken, then not taken
      offer(32'h0020_8063, 32'd5, 32'd5);
      check("beq_alu_op", {28'd0, alu_op}, 32'd10);
      check("beq_irmux", {30'd0, alu_irmux}, 32'd0);
      @(negedge clk);
      check("beq_taken", {31'd0, br_taken}, 32'd1);
      check("beq_wb_we", {31'd0, wb_we}, 32'd0);
      @(negedge clk);
      offer(32'h0020_8063, 32'd5, 32'd6);
      @(negedge clk);
      check("beq_not_taken", {31'd0, br_taken}, 32'd0);
      @(negedge clk);

      // ADDI x3,x1,-1 with the consumer stalling; SUB waits at the input
      wb_ready = 1'b0;
      offer(32'hFFF0_8193, 32'd687, 32'd0);
      check("addin_immi", alu_immi, 32'hFFFF_FFFF);
      @(negedge clk);
      instr_valid = 1'b1; instr = 32'h4020_8133; rs1_data = 32'd100; rs2_data = 32'd30;
      for (int k = 0; k < 5; k++) begin
         check("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
         check("stall_wb_data", wb_data, 32'd686);
         check("stall_wb_rd", {27'd0, wb_rd}, 32'd3);
         check("stall_wb_we", {31'd0, wb_we}, 32'd1);
         check("stall_ready", {31'd0, instr_ready}, 32'd0);
         @(negedge clk);
      end
      wb_ready = 1'b1;
      check("stall_last_valid", {31'd0, wb_valid}, 32'd1);
      check("stall_last_ready", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      check("post_hs_valid", {31'd0, wb_valid}, 32'd0);
      check("post_hs_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      check("sub_alu_op", {28'd0, alu_op}, 32'd1);
      check("sub_alu_a", alu_a, 32'd100);
      @(negedge clk);
      check("sub_wb_data", wb_data, 32'd70);
      check("sub_wb_rd", {27'd0, wb_rd}, 32'd2);
      check("sub_wb_we", {31'd0, wb_we}, 32'd1);
      @(negedge clk);

      // illegal opcode: straight to RESP
      offer(32'h0000_007F, 32'd1, 32'd2);
      check("ill_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("ill_err", {31'd0, err}, 32'd1);
      check("ill_wb_we", {31'd0, wb_we}, 32'd0);
      check("ill_wb_data", wb_data, 32'd0);
      check("ill_alu_op", {28'd0, alu_op}, 32'd0);
      @(negedge clk);
      check("ill_done_err", {31'd0, err}, 32'd0);

      // R-type funct7=0100000 funct3=001 and B-type funct3=010 are undefined
      offer(32'h4020_9033, 32'd1, 32'd2);
      check("ill_r_err", {31'd0, err}, 32'd1);
      @(negedge clk);
      offer(32'h0020_A063, 32'd1, 32'd2);
      check("ill_b_err", {31'd0, err}, 32'd1);
      @(negedge clk);

      // reset in the middle of EXEC discards the instruction
      offer(32'h00C0_8293, 32'd687, 32'd0);
      check("rexec_immi", alu_immi, 32'd12);
      rst = 1'b1;
      #1;
      check("rexec_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rexec_alu_a", alu_a, 32'd0);
      check("rexec_alu_immi", alu_immi, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rexec_ready", {31'd0, instr_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rexec_no_resp", {31'd0, wb_valid}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid  input  1  an instruction word is offered.
REQ-005 SHALL have port instr_ready  output  1  the block accepts the instruction word this cycle.
REQ-006 SHALL have port instr  input  32  RV32I instruction word.
REQ-007 SHALL have port rs1_data  input  DATA_W  register-file value for instr[19:15], valid with instr_valid.
REQ-008 SHALL have port rs2_data  input  DATA_W  register-file value for instr[24:20], valid with instr_valid.
REQ-009 SHALL have port alu_a  output  DATA_W  ALU operand A.
REQ-010 SHALL have port alu_rs2  output  DATA_W  ALU register operand B.
REQ-011 SHALL have port alu_imms  output  DATA_W  S-type immediate.
REQ-012 SHALL have port alu_immi  output  DATA_W  I-type immediate.
REQ-013 SHALL have port alu_irmux  output  2  ALU B select (0=rs2, 1=immi, 2=imms).
REQ-014 SHALL have port alu_op  output  4  ALU operation code.
REQ-015 SHALL have port alu_result  input  DATA_W  combinational ALU result.
REQ-016 SHALL have port alu_bt  input  1  ALU branch-taken flag.
REQ-017 SHALL have port wb_valid  output  1  response is valid.
REQ-018 SHALL have port wb_ready  input  1  consumer accepts the response.
REQ-019 SHALL have port wb_we  output  1  wb_data is to be written to wb_rd.
REQ-020 SHALL have port wb_rd  output  5  destination register, instr[11:7].
REQ-021 SHALL have port wb_data  output  DATA_W  captured alu_result.
REQ-022 SHALL have port br_taken  output  1  captured alu_bt; meaningful for B-type only.
REQ-023 SHALL have port err  output  1  the response is for an illegal instruction.

Function
REQ-024 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; instr_ready=1 only in IDLE.
REQ-025 SHALL, on instr_valid&&instr_ready, register instr, rs1_data and rs2_data, and go to EXEC (legal) or directly to RESP with err=1 (illegal).
REQ-026 SHALL, in EXEC, drive the ALU outputs from registers; alu_a=rs1, alu_rs2=rs2, alu_immi=sext(instr[31:20]), alu_imms=sext({instr[31:25],instr[11:7]}).
REQ-027 SHALL, at the end of EXEC, capture alu_result into wb_data and alu_bt into br_taken, then go to RESP; acceptance-to-wb_valid latency is exactly 2 cycles.
REQ-028 SHALL decode opcode 0110011 as R-type (irmux 0, wb_we 1), 0010011 as I-type (irmux 1, wb_we 1), 0100011 as S-type (irmux 2, alu_op ADD, wb_we 0), and 1100011 as B-type (irmux 0, wb_we 0).
REQ-029 SHALL map alu_op ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, BEQ=10, BNE=11, BLT=12, BGE=13, BLTU=14, BGEU=15 from funct3/funct7 (SUB/SRA when funct7=0100000).
REQ-030 SHALL flag as illegal any other opcode, any undefined funct3/funct7 combination, or B-type funct3 010/011; on illegal: err=1, wb_we=0, wb_data=0.
REQ-031 SHALL hold all wb_* outputs, br_taken and err stable in RESP until wb_ready; on wb_valid&&wb_ready, return to IDLE (next accept no earlier than the following cycle).
REQ-032 SHALL drive wb_valid=0 outside RESP and all ALU outputs to 0 outside EXEC.
REQ-033 SHALL force wb_we=0 when wb_rd=0.

Reset
REQ-034 SHALL, on rst, immediately enter IDLE and drive every output to 0 except instr_ready, which is 1 after rst deasserts; any in-flight instruction is discarded without a response.
REQ-035 SHALL accept its first instruction on the first rising edge after rst deasserts.

Structure
REQ-036 SHALL place the alu_op codes, the irmux codes, the RV32I opcode constants and the FSM state type in shared package alu_pkg.
REQ-037 SHALL isolate the combinational instruction decode in sub-module alu_decode (instr -> alu_op, irmux, wb_we, illegal).

Verification
REQ-038 SHALL check: R-type ADD (0x00208033), rs1=687, rs2=1684168 -> alu_op 0, irmux 0; 2 cycles later wb_valid, wb_data=1684855, wb_we=1, wb_rd=0 -> wb_we forced 0.
REQ-039 SHALL check: ADDI x5,x1,12 (0x00C08293), rs1=687 -> irmux 1, alu_immi=12, wb_data=699, wb_rd=5, wb_we=1.
REQ-040 SHALL check: SW with imm 12, rs1=687 -> irmux 2, alu_imms=12, wb_data=699, wb_we=0; BEQ with rs1=rs2=5 -> alu_op 10, br_taken=1.
REQ-041 SHALL check: wb_ready held low for 5 cycles in RESP -> outputs stable, instr_ready=0 throughout; accept resumes one cycle after the handshake.
REQ-042 SHALL check: instr=0x0000007F -> RESP 1 cycle after accept with err=1, wb_we=0; rst pulsed during EXEC -> no wb_valid, instr_ready=1 after release.
